// File: rtl/toggle_fsm_sequencer_pkg.sv
// Shared definitions for the toggle machine sequencer: FSM encodings and
// the fixed signal levels used when driving and checking the target.
package toggle_fsm_sequencer_pkg;

  localparam logic [1:0] ENC_IDLE       = 2'd0;
  localparam logic [1:0] ENC_DRIVE_LOW  = 2'd1;
  localparam logic [1:0] ENC_DRIVE_HIGH = 2'd2;
  localparam logic [1:0] ENC_FINISH     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = ENC_IDLE,
    ST_DRIVE_LOW  = ENC_DRIVE_LOW,
    ST_DRIVE_HIGH = ENC_DRIVE_HIGH,
    ST_FINISH     = ENC_FINISH
  } seq_state_t;

  // y level that parks the target in state_a (x = 0).
  localparam logic Y_IDLE = 1'b1;

  // Settled x level the target must show while y is held low / high.
  localparam logic X_EXP_LOW  = 1'b1;
  localparam logic X_EXP_HIGH = 1'b0;

endpackage

// File: rtl/toggle_fsm_sequencer_seq_down_counter.sv
// Loadable down-counter. tc_o flags a count of exactly 1, i.e. the current
// cycle is the last one of the interval that was loaded.
module toggle_fsm_sequencer_seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc_o = (count_q == W'(1));

endmodule

// File: rtl/toggle_fsm_sequencer.sv
// Sequencer for the two-state toggle machine: drives y with a programmable
// low/high pulse train, checks the Moore response x one cycle behind y, and
// reports busy / done / error / saturating mismatch count.
//
// Handshake: start is a single-cycle request, accepted only in IDLE. busy
// rises the cycle after acceptance and stays high through FINISH; done is
// a one-cycle pulse in the cycle after FINISH, when busy is already low.
module toggle_fsm_sequencer
  import toggle_fsm_sequencer_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int REP_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [REP_W-1:0] repeat_count,
  output logic             y_out,
  input  logic             x_in,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ERR_W-1:0] mismatch_count,
  output logic [1:0]       fsm_state
);

  seq_state_t       state_q;
  logic             y_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [ERR_W-1:0] mcount_q;
  logic             first_q;
  logic [CNT_W-1:0] low_len_q;
  logic [CNT_W-1:0] high_len_q;

  logic             ph_load_d;
  logic [CNT_W-1:0] ph_val_d;
  logic             ph_dec_d;
  logic             ph_tc;
  logic             pr_load_d;
  logic             pr_dec_d;
  logic             pr_tc;
  logic             chk_fail_d;

  // A zero phase length is promoted to one cycle.
  function automatic logic [CNT_W-1:0] len_or_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Counter control: load the next phase length at every phase boundary,
  // count down otherwise; the period counter steps at the end of each high.
  always_comb begin
    ph_load_d = 1'b0;
    ph_val_d  = low_len_q;
    ph_dec_d  = 1'b0;
    pr_load_d = 1'b0;
    pr_dec_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ph_load_d = 1'b1;
          ph_val_d  = len_or_one(low_cycles);
          pr_load_d = 1'b1;
        end
      end
      ST_DRIVE_LOW: begin
        if (ph_tc) begin
          ph_load_d = 1'b1;
          ph_val_d  = high_len_q;
        end else begin
          ph_dec_d = 1'b1;
        end
      end
      ST_DRIVE_HIGH: begin
        if (ph_tc) begin
          pr_dec_d  = 1'b1;
          ph_load_d = 1'b1;
          ph_val_d  = low_len_q;
        end else begin
          ph_dec_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response check: the first cycle of a phase still shows the old x.
  always_comb begin
    chk_fail_d = 1'b0;
    if (!first_q) begin
      if (state_q == ST_DRIVE_LOW)  chk_fail_d = (x_in != X_EXP_LOW);
      if (state_q == ST_DRIVE_HIGH) chk_fail_d = (x_in != X_EXP_HIGH);
    end
  end

  toggle_fsm_sequencer_seq_down_counter #(.W(CNT_W)) u_phase_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (ph_load_d),
    .load_val_i (ph_val_d),
    .dec_i      (ph_dec_d),
    .tc_o       (ph_tc)
  );

  toggle_fsm_sequencer_seq_down_counter #(.W(REP_W)) u_period_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (pr_load_d),
    .load_val_i (repeat_count),
    .dec_i      (pr_dec_d),
    .tc_o       (pr_tc)
  );

  // Sequencer FSM with registered y/busy/done and the mismatch bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      y_q        <= Y_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mcount_q   <= '0;
      first_q    <= 1'b0;
      low_len_q  <= '0;
      high_len_q <= '0;
    end else begin
      done_q  <= 1'b0;
      first_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          y_q <= Y_IDLE;
          if (start) begin
            low_len_q  <= len_or_one(low_cycles);
            high_len_q <= len_or_one(high_cycles);
            error_q    <= 1'b0;
            mcount_q   <= '0;
            busy_q     <= 1'b1;
            if (repeat_count == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_DRIVE_LOW;
              y_q     <= 1'b0;
              first_q <= 1'b1;
            end
          end
        end
        ST_DRIVE_LOW: begin
          if (ph_tc) begin
            state_q <= ST_DRIVE_HIGH;
            y_q     <= 1'b1;
            first_q <= 1'b1;
          end
        end
        ST_DRIVE_HIGH: begin
          if (ph_tc) begin
            if (pr_tc) begin
              state_q <= ST_FINISH;
              y_q     <= Y_IDLE;
            end else begin
              state_q <= ST_DRIVE_LOW;
              y_q     <= 1'b0;
              first_q <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          y_q     <= Y_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          y_q     <= Y_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (chk_fail_d) begin
        error_q <= 1'b1;
        if (mcount_q != {ERR_W{1'b1}}) mcount_q <= mcount_q + 1'b1;
      end
    end
  end

  assign y_out          = y_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign mismatch_count = mcount_q;
  assign fsm_state      = state_q;

endmodule
